mips32_mem_arbiter: RTL and testbench

Shares the single-port 32-bit data/instruction memory of the pipe_MIPS32 core between three requesters: the MEM-stage load/store port, the IF-stage fetch port, and a debug/loader port used to preload programs and read results. Fixed priority with a fetch anti-starvation counter and a debug lock that gives the loader exclusive access. It sits between the core and the memory macro, with one read-data return tag pipeline.

---
 rtl/mips32_mem_arbiter.sv | 78 +++++++
 tb/tb_mips32_mem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: shares one single-port memory between the data, fetch and debug requesters.
// Fixed priority with fetch anti-starvation, a debug exclusive-access lock and a read-return tag.
module mips32_mem_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    input  logic          g_req,
    input  logic          g_we,
    input  logic [AW-1:0] g_addr,
    input  logic [DW-1:0] g_wdata,
    input  logic          g_lock,
    output logic          g_gnt,
    output logic          g_rvalid,
    output logic          g_locked,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic {OPEN, LOCKED} state_e;
    typedef enum logic [1:0] {TAG_NONE, TAG_D, TAG_F, TAG_G} tag_e;
    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    state_e     state_q, state_d;
    tag_e       tag_q, tag_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       is_open, force_f;

    always_comb begin
        is_open      = state_q == OPEN;
        force_f      = f_req && starve_cnt_q == MAX_CNT;
        // grants are gated by reset so nothing reaches memory while rst_n is low
        d_gnt        = rst_n && is_open && d_req && !force_f;
        f_gnt        = rst_n && is_open && f_req && (force_f || !d_req);
        g_gnt        = rst_n && g_req && (!is_open || (!d_req && !f_req));
        mem_en       = d_gnt || f_gnt || g_gnt;
        mem_we       = (d_gnt && d_we) || (g_gnt && g_we);
        mem_addr     = d_gnt ? d_addr : f_gnt ? f_addr : g_gnt ? g_addr : '0;
        mem_wdata    = d_gnt ? d_wdata : g_gnt ? g_wdata : '0;
        tag_d        = (!mem_en || mem_we) ? TAG_NONE : d_gnt ? TAG_D : f_gnt ? TAG_F : TAG_G;
        state_d      = (g_lock && (!is_open || tag_q == TAG_NONE)) ? LOCKED : OPEN;
        starve_cnt_d = (is_open && state_d == OPEN && f_req && !f_gnt) ?
                       (starve_cnt_q == MAX_CNT ? starve_cnt_q : starve_cnt_q + 4'd1) : '0;
    end

    assign d_rvalid = tag_q == TAG_D;
    assign f_rvalid = tag_q == TAG_F;
    assign g_rvalid = tag_q == TAG_G;
    assign g_locked = state_q == LOCKED;
    assign rdata    = tag_q != TAG_NONE ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= OPEN;
            tag_q        <= TAG_NONE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter: directed scenarios plus randomized traffic checked against
// a cycle-level reference model of the arbitration rules and a shadow memory.
module tb_mips32_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic f_req, f_gnt, f_rvalid;
    logic [AW-1:0] f_addr;
    logic g_req, g_we, g_lock, g_gnt, g_rvalid, g_locked;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic mem_en, mem_we;
    logic [AW-1:0] mem_addr;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] mem [1<<AW];
    logic [DW-1:0] ref_mem [1<<AW];
    bit m_locked;
    int m_wait, m_pend, m_w;
    logic [DW-1:0] m_pdata;
    logic [2:0] obs_gnt, obs_rv;
    logic [DW-1:0] obs_rdata;
    logic obs_locked;

    always #5 clk = ~clk;

    mips32_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata), .g_lock(g_lock),
        .g_gnt(g_gnt), .g_rvalid(g_rvalid), .g_locked(g_locked),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // memory macro: one-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_wait = 0;
        m_pend = 0;
        m_pdata = '0;
        m_w = 0;
    endtask

    task automatic idle();
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        f_req = 0; f_addr = '0;
        g_req = 0; g_we = 0; g_addr = '0; g_wdata = '0; g_lock = 0;
    endtask

    task automatic cycle();
        logic [2:0] eg;
        logic ewe, enter;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        @(negedge clk);
        if (!rst_n) m_w = 0;
        else if (m_locked) m_w = g_req ? 3 : 0;
        else if (f_req && m_wait >= MAX_WAIT) m_w = 2;
        else m_w = d_req ? 1 : f_req ? 2 : g_req ? 3 : 0;
        eg = m_w == 1 ? 3'b100 : m_w == 2 ? 3'b010 : m_w == 3 ? 3'b001 : 3'b000;
        ewe = m_w == 1 ? d_we : m_w == 3 ? g_we : 1'b0;
        ea = m_w == 1 ? d_addr : m_w == 2 ? f_addr : m_w == 3 ? g_addr : '0;
        ewd = m_w == 1 ? d_wdata : g_wdata;
        obs_gnt = {d_gnt, f_gnt, g_gnt};
        obs_rv = {d_rvalid, f_rvalid, g_rvalid};
        obs_rdata = rdata;
        obs_locked = g_locked;
        check("gnt", obs_gnt, eg);
        check("mem_en", mem_en, m_w != 0);
        check("mem_we", mem_we, ewe);
        check("mem_addr", mem_addr, ea);
        if (ewe) check("mem_wdata", mem_wdata, ewd);
        if (m_w == 0) check("mem_wdata_idle", mem_wdata, 0);
        check("rvalid", obs_rv, m_pend == 1 ? 3'b100 : m_pend == 2 ? 3'b010 : m_pend == 3 ? 3'b001 : 3'b000);
        check("rdata", obs_rdata, m_pend != 0 ? m_pdata : '0);
        check("locked", obs_locked, m_locked);
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            enter = !m_locked && g_lock && m_pend == 0;
            if (ewe) ref_mem[ea] = ewd;
            m_pend = (m_w != 0 && !ewe) ? m_w : 0;
            m_pdata = ref_mem[ea];
            m_wait = (!m_locked && !enter && f_req && m_w != 2) ? (m_wait < MAX_WAIT ? m_wait + 1 : MAX_WAIT) : 0;
            m_locked = m_locked ? g_lock : enter;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[200] = 7;
        ref_mem[200] = 7;
        model_reset();
        idle();
        // reset held with every request high
        d_req = 1; f_req = 1; g_req = 1; d_addr = 10'd3; f_addr = 10'd4; g_addr = 10'd5;
        cycle();
        check("rst_gnt", obs_gnt, 3'b000);
        check("rst_mem_en", mem_en, 0);
        check("rst_locked", obs_locked, 0);
        rst_n = 1;
        cycle();
        check("first_gnt", obs_gnt, 3'b100);
        idle();
        cycle();
        cycle();
        // data read of Mem[200]
        d_req = 1; d_addr = 10'd200;
        cycle();
        check("rd_gnt", obs_gnt, 3'b100);
        idle();
        cycle();
        check("rd_rv", obs_rv, 3'b100);
        check("rd_data", obs_rdata, 7);
        // starvation: fetch wins every fifth cycle
        d_req = 1; d_addr = 10'd5; f_req = 1; f_addr = 10'd6;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("starve", obs_gnt, (i % 5 == 4) ? 3'b010 : 3'b100);
        end
        idle();
        cycle();
        // simultaneous requests
        d_req = 1; d_addr = 10'd20; f_req = 1; f_addr = 10'd21; g_req = 1; g_addr = 10'd22;
        cycle();
        check("sim_d", obs_gnt, 3'b100);
        d_req = 0;
        cycle();
        check("sim_f", obs_gnt, 3'b010);
        check("sim_rv_d", obs_rv, 3'b100);
        f_req = 0;
        cycle();
        check("sim_g", obs_gnt, 3'b001);
        check("sim_rv_f", obs_rv, 3'b010);
        g_req = 0;
        cycle();
        check("sim_rv_g", obs_rv, 3'b001);
        // debug lock raised while a fetch read is outstanding
        f_req = 1; f_addr = 10'd7;
        cycle();
        check("lk_fgnt", obs_gnt, 3'b010);
        f_req = 0; g_lock = 1;
        cycle();
        check("lk_frv", obs_rv, 3'b010);
        check("lk_notyet", obs_locked, 0);
        cycle();
        cycle();
        check("lk_on", obs_locked, 1);
        d_req = 1; d_addr = 10'd9; f_req = 1; f_addr = 10'd8;
        g_req = 1; g_we = 1; g_addr = 10'd198; g_wdata = 32'd5040;
        cycle();
        check("lk_gw", obs_gnt, 3'b001);
        g_we = 0;
        cycle();
        check("lk_gr", obs_gnt, 3'b001);
        g_req = 0;
        cycle();
        check("lk_none", obs_gnt, 3'b000);
        check("lk_rdata", obs_rdata, 5040);
        g_lock = 0;
        cycle();
        check("lk_hold", obs_gnt, 3'b000);
        cycle();
        check("unlk_gnt", obs_gnt, 3'b100);
        check("unlk", obs_locked, 0);
        idle();
        cycle();
        // reset in the cycle after a read grant
        d_req = 1; d_addr = 10'd200;
        cycle();
        check("mr_gnt", obs_gnt, 3'b100);
        idle();
        rst_n = 0;
        model_reset();
        cycle();
        check("mr_rv", obs_rv, 3'b000);
        check("mr_rdata", obs_rdata, 0);
        check("mr_mem_en", mem_en, 0);
        rst_n = 1;
        cycle();
        // randomized traffic, requests held until granted
        for (int n = 0; n < 3000; n++) begin
            if (!d_req || m_w == 1) begin
                d_req = $urandom % 3 != 0; d_we = $urandom % 2;
                d_addr = AW'($urandom % 16); d_wdata = $urandom;
            end
            if (!f_req || m_w == 2) begin
                f_req = $urandom % 2 == 0; f_addr = AW'($urandom % 16);
            end
            if (!g_req || m_w == 3) begin
                g_req = $urandom % 4 == 0; g_we = $urandom % 2;
                g_addr = AW'($urandom % 16); g_wdata = $urandom;
            end
            if ($urandom % 25 == 0) g_lock = !g_lock;
            cycle();
        end
        idle();
        cycle();
        cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
